// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM states and response-tag type for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 9;
    localparam int unsigned NUM_REQ        = 2;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Read-tag travelling with an accepted read: which requester gets the data.
    typedef struct packed {
        logic valid;
        logic idx;
    } rsp_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; the caller owns the pointer register.
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant
);

    // On a tie the requester not served last wins.
    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Zero-fills a single-port SRAM macro after reset, then round-robins its port
// between two requesters and returns read data with fixed latency.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                            clk0,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wmask,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            init_done,
    output logic                            sram_csb0,
    output logic                            sram_web0,
    output logic [DATA_WIDTH-1:0]           sram_wmask0,
    output logic [ADDR_WIDTH-1:0]           sram_addr0,
    output logic [DATA_WIDTH-1:0]           sram_din0,
    input  logic [DATA_WIDTH-1:0]           sram_dout0
);

    state_e                  state;
    state_e                  state_nxt;
    logic [ADDR_WIDTH-1:0]   fill_cnt;
    logic                    fill_last;
    logic                    last;
    logic [NUM_REQ-1:0]      pick;
    logic                    sel;
    rsp_tag_t                issue_tag;

    assign fill_last = (fill_cnt == {ADDR_WIDTH{1'b1}});
    assign sel       = pick[1];

    rr_pick2 u_pick (
        .valid (req_valid),
        .last  (last),
        .grant (pick)
    );

    always_comb begin
        state_nxt = state;
        if ((state == INIT) && fill_last) begin
            state_nxt = RUN;
        end
    end

    // Grant and macro drive; the port idles while reset is high or nothing is granted.
    always_comb begin
        req_ready   = '0;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (!reset) begin
            if (state == INIT) begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = fill_cnt;
            end else begin
                req_ready = pick;
                if (|pick) begin
                    sram_csb0   = 1'b0;
                    sram_web0   = ~req_we[sel];
                    sram_addr0  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                      : req_addr[ADDR_WIDTH-1:0];
                    sram_din0   = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : req_wdata[DATA_WIDTH-1:0];
                    sram_wmask0 = sel ? req_wmask[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : req_wmask[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state     <= INIT;
            fill_cnt  <= '0;
            last      <= 1'b1;
            init_done <= 1'b0;
            issue_tag <= '0;
            rsp_valid <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
            end
            if ((state == INIT) && fill_last) begin
                init_done <= 1'b1;
            end
            if (|req_ready) begin
                last <= req_ready[1];
            end
            issue_tag.valid <= |(req_ready & ~req_we);
            issue_tag.idx   <= req_ready[1];
            rsp_valid       <= issue_tag.valid ? (issue_tag.idx ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    // Macro output settles after the issue edge; sample it mid-cycle.
    always_ff @(negedge clk0) begin
        if (reset) begin
            rsp_rdata <= '0;
        end else if (issue_tag.valid) begin
            rsp_rdata <= sram_dout0;
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: behavioural macro, reference memory and response scoreboard.
module tb_sram_rr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;
    localparam int unsigned DEPTH = 512;

    logic            clk0 = 1'b0;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*DW-1:0] req_wmask;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            init_done;
    logic            sram_csb0;
    logic            sram_web0;
    logic [DW-1:0]   sram_wmask0;
    logic [AW-1:0]   sram_addr0;
    logic [DW-1:0]   sram_din0;
    logic [DW-1:0]   sram_dout0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic        idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] ref_mem [DEPTH];

    // Behavioural macro: inputs registered at posedge, write at negedge, read data after posedge.
    logic [31:0] mem [DEPTH];
    logic        csb_q = 1'b1;
    logic        web_q = 1'b1;
    logic [8:0]  addr_q;
    logic [31:0] din_q;
    logic [31:0] wm_q;
    logic [31:0] dout_q = 32'h0;

    assign sram_dout0 = dout_q;

    always @(posedge clk0) begin
        csb_q  <= sram_csb0;
        web_q  <= sram_web0;
        addr_q <= sram_addr0;
        din_q  <= sram_din0;
        wm_q   <= sram_wmask0;
        if (!sram_csb0 && sram_web0) dout_q <= mem[sram_addr0];
    end

    always @(negedge clk0) begin
        if (!csb_q && !web_q) mem[addr_q] <= (mem[addr_q] & ~wm_q) | (din_q & wm_q);
    end

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    sram_rr_arbiter dut (
        .clk0        (clk0),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [8:0] a,
                           input logic [31:0] d, input logic [31:0] m);
        req_valid[i]           = 1'b1;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_wmask[i*DW +: DW]  = m;
    endtask

    // Called at posedge+2 with inputs set; records handshakes, returns at next posedge+2.
    task automatic step();
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] m;
        exp_t        e;
        #1;
        check("ready_not_both", 64'(req_ready == 2'b11), 64'(0));
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                a = req_addr[i*AW +: AW];
                d = req_wdata[i*DW +: DW];
                m = req_wmask[i*DW +: DW];
                if (req_we[i]) begin
                    ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
                end else begin
                    e.due  = cyc + 2;
                    e.idx  = 1'(i);
                    e.data = ref_mem[a];
                    sb.push_back(e);
                end
                grant_log.push_back(i);
            end
        end
        @(posedge clk0);
        #2;
    endtask

    task automatic single(input int i, input logic we, input logic [8:0] a,
                          input logic [31:0] d, input logic [31:0] m);
        set_req(i, we, a, d, m);
        step();
        req_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        for (int k = 0; k < n; k++) step();
    endtask

    // Response monitor: every cycle either the due response or silence.
    always @(posedge clk0) begin
        exp_t e;
        #2;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e.idx ? 2'b10 : 2'b01));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
        end else begin
            check("rsp_idle", 64'(rsp_valid), 64'(0));
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k]     = 32'hA5A5_A5A5 ^ 32'(k);
            ref_mem[k] = 32'h0;
        end
        reset     = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {9'h1AB, 9'h0CD};
        req_wdata = {32'h1234_5678, 32'h9ABC_DEF0};
        req_wmask = '1;

        repeat (3) @(posedge clk0);
        #2;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_macro", 64'({sram_csb0, sram_web0, sram_addr0, |sram_din0, |sram_wmask0}),
              64'({1'b1, 1'b1, 9'd0, 1'b0, 1'b0}));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));

        // Zero-fill window with both requesters pushing.
        reset = 1'b0;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            check("fill", 64'({init_done, req_ready, sram_csb0, sram_web0, &sram_wmask0,
                               |sram_din0, sram_addr0}),
                  64'({1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 9'(k)}));
            @(posedge clk0);
            #1;
        end
        req_valid = 2'b00;
        check("init_done_rise", 64'(init_done), 64'(1));
        @(posedge clk0);
        #2;

        single(0, 1'b0, 9'h1FF, 32'h0, 32'h0);
        single(0, 1'b1, 9'h005, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        single(0, 1'b0, 9'h005, 32'h0, 32'h0);
        idle(3);

        single(0, 1'b1, 9'h020, 32'h1111_1111, 32'hFFFF_FFFF);
        single(1, 1'b1, 9'h021, 32'h2222_2222, 32'hFFFF_FFFF);
        single(1, 1'b1, 9'h010, 32'hFFFF_FFFF, 32'h0000_FFFF);
        single(1, 1'b0, 9'h010, 32'h0, 32'h0);
        idle(3);

        // Contention: both hold valid, grants must alternate starting at 0.
        grant_log.delete();
        set_req(0, 1'b0, 9'h020, 32'h0, 32'h0);
        set_req(1, 1'b0, 9'h021, 32'h0, 32'h0);
        repeat (4) step();
        idle(4);
        check("grant_count", 64'(grant_log.size()), 64'(4));
        for (int k = 0; k < grant_log.size(); k++) begin
            check($sformatf("grant_seq%0d", k), 64'(grant_log[k]), 64'(k % 2));
        end

        // Write then read of the same address from opposite requesters.
        single(0, 1'b1, 9'h030, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        single(1, 1'b0, 9'h030, 32'h0, 32'h0);
        idle(4);
        check("sb_drain", 64'(sb.size()), 64'(0));

        // Reset in the cycle after a read is accepted.
        single(0, 1'b0, 9'h005, 32'h0, 32'h0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk0);
        #2;
        check("rst_mid_csb", 64'({sram_csb0, sram_web0, req_ready}), 64'({1'b1, 1'b1, 2'b00}));
        @(posedge clk0);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("refill", 64'({init_done, req_ready, sram_csb0, sram_web0, rsp_rdata, sram_addr0}),
                  64'({1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 9'(k)}));
            @(posedge clk0);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
